// File: rtl/nand_chk_pkg.sv
// rtl/nand_chk_pkg.sv - shared state encoding, FIFO entry layout and NAND expectation model
package nand_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_FAIL
  } chk_state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic exp;
  } exp_entry_t;

  localparam int ENTRY_W = 3;

  // A floating (z) input reads as unknown, so only solid 0/1 values decide the result.
  function automatic logic nand_expect(input logic a, input logic b);
    if ((a === 1'b0) || (b === 1'b0)) return 1'b1;
    if ((a === 1'b1) && (b === 1'b1)) return 1'b0;
    return 1'bx;
  endfunction

endpackage

// File: rtl/chk_exp_fifo.sv
// rtl/chk_exp_fifo.sv - expectation FIFO, DEPTH entries, full/empty flags, no read bypass
module chk_exp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign rdata_o = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nand_result_checker.sv
// rtl/nand_result_checker.sv - NAND scoreboard top; NAND_CHK_XSTRICT_EN selects strict 4-state compare
module nand_result_checker
  import nand_chk_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int NUM_VECTORS = 14,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stim_valid_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             resp_valid_i,
  input  logic             c_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [3:0]       fail_vec_o
);

  localparam int VC_W = $clog2(NUM_VECTORS + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [VC_W-1:0] LP_NV    = VC_W'(NUM_VECTORS);
  localparam logic [VC_W-1:0] LP_NV_M1 = VC_W'(NUM_VECTORS - 1);
  localparam logic [TO_W-1:0] LP_TO_M1 = TO_W'(TIMEOUT - 1);

  chk_state_t       r_state;
  chk_state_t       w_next_state;
  logic [VC_W-1:0]  r_push_cnt;
  logic [VC_W-1:0]  r_cmp_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_mismatch_cnt;
  logic [3:0]       r_fail_vec;
  logic             r_vec_captured;
  logic             r_fail;
  logic             r_timeout;
  logic             r_overflow;
  logic             r_underflow;

  logic               w_active;
  logic               w_full;
  logic               w_empty;
  logic               w_push_req;
  logic               w_push;
  logic               w_pop;
  logic               w_underflow;
  logic               w_overflow;
  logic               w_match;
  logic               w_mismatch;
  logic               w_to_hit;
  logic [3:0]         w_fail_vec;
  exp_entry_t         w_wr_entry;
  exp_entry_t         w_head;
  logic [ENTRY_W-1:0] w_head_bits;

  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_push_req  = (r_state == S_RUN) && stim_valid_i;
  assign w_pop       = w_active && resp_valid_i && !w_empty;
  assign w_underflow = w_active && resp_valid_i && w_empty;
  assign w_overflow  = w_push_req && w_full && !w_pop;
  assign w_push      = w_push_req && !w_overflow;
  assign w_wr_entry  = {a_i, b_i, nand_expect(a_i, b_i)};
  assign w_head      = exp_entry_t'(w_head_bits);

  chk_exp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_push),
    .wdata_i (w_wr_entry),
    .pop_i   (w_pop),
    .rdata_o (w_head_bits),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

`ifdef NAND_CHK_XSTRICT_EN
  assign w_match = (c_i === w_head.exp);
`else
  // An unknown expectation cannot be judged, so any response is accepted.
  assign w_match = (w_head.exp === 1'bx) || (c_i === w_head.exp);
`endif

  assign w_mismatch = (w_pop && !w_match) || w_underflow;
  assign w_fail_vec = w_underflow ? {3'bxxx, c_i} : {w_head.a, w_head.b, w_head.exp, c_i};
  assign w_to_hit   = w_active && !w_empty && !w_pop && (r_to_cnt == LP_TO_M1);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next_state = S_RUN;
      S_RUN: begin
        if (w_to_hit) w_next_state = S_FAIL;
        else if (w_push && (r_push_cnt == LP_NV_M1)) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_to_hit) w_next_state = S_FAIL;
        else if (w_empty && (r_cmp_cnt == LP_NV)) w_next_state = S_DONE;
      end
      default: w_next_state = r_state;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_push_cnt     <= '0;
      r_cmp_cnt      <= '0;
      r_to_cnt       <= '0;
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_fail_vec     <= 4'b0000;
      r_vec_captured <= 1'b0;
      r_fail         <= 1'b0;
      r_timeout      <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_push) r_push_cnt <= r_push_cnt + VC_W'(1);
      if (w_pop)  r_cmp_cnt  <= r_cmp_cnt + VC_W'(1);

      if (!w_active || w_empty || w_pop) r_to_cnt <= '0;
      else if (r_to_cnt != '1)           r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_pop && w_match && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + CNT_W'(1);
      if (w_mismatch && (r_mismatch_cnt != '1))    r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);

      if (w_mismatch && !r_vec_captured) begin
        r_fail_vec     <= w_fail_vec;
        r_vec_captured <= 1'b1;
      end

      if (w_underflow) r_underflow <= 1'b1;
      if (w_overflow)  r_overflow  <= 1'b1;
      if (w_to_hit)    r_timeout   <= 1'b1;
      if (w_mismatch || w_overflow || w_to_hit) r_fail <= 1'b1;
    end
  end

  assign busy_o         = w_active;
  assign pass_o         = (r_state == S_DONE) && !r_fail;
  assign fail_o         = r_fail;
  assign timeout_o      = r_timeout;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;
  assign match_cnt_o    = r_match_cnt;
  assign mismatch_cnt_o = r_mismatch_cnt;
  assign fail_vec_o     = r_fail_vec;

endmodule

// File: tb/tb_nand_result_checker.sv
// tb/tb_nand_result_checker.sv - self-checking bench for nand_result_checker
module tb_nand_result_checker;

  localparam int N = 14;

  logic clk = 1'b0;
  logic rst_n, start, stim_valid, a, b, resp_valid, c;
  logic busy, pass, fail, tmo, ovf, udf;
  logic [7:0] match_cnt, mismatch_cnt;
  logic [3:0] fail_vec;

  int n_chk = 0;
  int n_err = 0;

  logic va [16];
  logic vb [16];
  logic vc [16];
  int   push_t [16];
  int   resp_t [16];

  nand_result_checker u_dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .stim_valid_i   (stim_valid),
    .a_i            (a),
    .b_i            (b),
    .resp_valid_i   (resp_valid),
    .c_i            (c),
    .busy_o         (busy),
    .pass_o         (pass),
    .fail_o         (fail),
    .timeout_o      (tmo),
    .overflow_o     (ovf),
    .underflow_o    (udf),
    .match_cnt_o    (match_cnt),
    .mismatch_cnt_o (mismatch_cnt),
    .fail_vec_o     (fail_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  // Reference rules: a solid 0 anywhere forces 1, two solid 1s give 0, anything else is unknown.
  function automatic logic exp_of(input logic x, input logic y);
    if ((x === 1'b0) || (y === 1'b0)) return 1'b1;
    if ((x === 1'b1) && (y === 1'b1)) return 1'b0;
    return 1'bx;
  endfunction

  function automatic logic judged_ok(input logic e, input logic g);
`ifdef NAND_CHK_XSTRICT_EN
    return (g === e);
`else
    return (e === 1'bx) || (g === e);
`endif
  endfunction

  function automatic logic [1:0] sweep_pair(input int i);
    case (i)
      0: return 2'bxx;   1: return 2'bzz;   2: return 2'b0x;   3: return 2'bx0;
      4: return 2'b0z;   5: return 2'bz0;   6: return 2'b1x;   7: return 2'bx1;
      8: return 2'b1z;   9: return 2'bz1;  10: return 2'b00;  11: return 2'b01;
      12: return 2'b10;  default: return 2'b11;
    endcase
  endfunction

  function automatic logic rand4();
    case ($urandom_range(0, 5))
      0, 1:    return 1'b0;
      2, 3:    return 1'b1;
      4:       return 1'bx;
      default: return 1'bz;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stim_valid = 1'b0; resp_valid = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_sweep(input int lat, input bit fault);
    logic [1:0] p;
    for (int i = 0; i < N; i++) begin
      p = sweep_pair(i);
      va[i] = p[1];
      vb[i] = p[0];
      vc[i] = ~(va[i] & vb[i]);
      if (fault && (i == N - 1)) vc[i] = 1'b1;
      push_t[i] = i;
      resp_t[i] = i + lat;
    end
  endtask

  task automatic run_sched(input int n, input int cycles);
    for (int t = 0; t < cycles; t++) begin
      stim_valid = 1'b0; resp_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (push_t[i] == t) begin stim_valid = 1'b1; a = va[i]; b = vb[i]; end
        if (resp_t[i] == t) begin resp_valid = 1'b1; c = vc[i]; end
      end
      @(posedge clk); #1;
    end
    stim_valid = 1'b0; resp_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((busy === 1'b1) && (k < 40)) begin
      @(posedge clk); #1;
      k++;
    end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_done_wait busy=%b exp=0", name, busy); end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass got=%b exp=0", pass); end
    n_chk++; if ({fail, tmo, ovf, udf} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {fail, tmo, ovf, udf}); end
    n_chk++; if ({match_cnt, mismatch_cnt} !== 16'h0) begin n_err++; $display("FAIL reset_counts got=%h exp=0000", {match_cnt, mismatch_cnt}); end
    n_chk++; if (fail_vec !== 4'b0000) begin n_err++; $display("FAIL reset_fail_vec got=%b exp=0000", fail_vec); end
  endtask

  task automatic test_idle_ignore();
    do_reset();
    stim_valid = 1'b1; resp_valid = 1'b1; a = 1'b1; b = 1'b1; c = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    stim_valid = 1'b0; resp_valid = 1'b0;
    n_chk++; if ({busy, udf, fail} !== 3'b000) begin n_err++; $display("FAIL idle_ignore_flags got=%b exp=000", {busy, udf, fail}); end
    n_chk++; if (mismatch_cnt !== 8'd0) begin n_err++; $display("FAIL idle_ignore_mismatch got=%0d exp=0", mismatch_cnt); end
  endtask

  task automatic test_sweep();
    do_reset();
    start_run();
    n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL sweep_busy got=%b exp=1", busy); end
    fill_sweep(1, 1'b0);
    run_sched(N, N + 2);
    wait_done("sweep");
    n_chk++; if (pass !== 1'b1) begin n_err++; $display("FAIL sweep_pass got=%b exp=1", pass); end
    n_chk++; if (match_cnt !== 8'd14) begin n_err++; $display("FAIL sweep_match got=%0d exp=14", match_cnt); end
    n_chk++; if (mismatch_cnt !== 8'd0) begin n_err++; $display("FAIL sweep_mismatch got=%0d exp=0", mismatch_cnt); end
  endtask

  task automatic test_fault();
    do_reset();
    start_run();
    fill_sweep(1, 1'b1);
    run_sched(N, N + 2);
    wait_done("fault");
    n_chk++; if (fail !== 1'b1) begin n_err++; $display("FAIL fault_fail got=%b exp=1", fail); end
    n_chk++; if (mismatch_cnt !== 8'd1) begin n_err++; $display("FAIL fault_mismatch got=%0d exp=1", mismatch_cnt); end
    n_chk++; if (match_cnt !== 8'd13) begin n_err++; $display("FAIL fault_match got=%0d exp=13", match_cnt); end
    n_chk++; if (fail_vec !== 4'b1101) begin n_err++; $display("FAIL fault_vec got=%b exp=1101", fail_vec); end
    n_chk++; if (pass !== 1'b0) begin n_err++; $display("FAIL fault_pass got=%b exp=0", pass); end
  endtask

  task automatic test_full_latency();
    do_reset();
    start_run();
    fill_sweep(8, 1'b0);
    run_sched(N, N + 10);
    wait_done("full_lat");
    n_chk++; if (ovf !== 1'b0) begin n_err++; $display("FAIL full_lat_overflow got=%b exp=0", ovf); end
    n_chk++; if (pass !== 1'b1) begin n_err++; $display("FAIL full_lat_pass got=%b exp=1", pass); end
    n_chk++; if (match_cnt !== 8'd14) begin n_err++; $display("FAIL full_lat_match got=%0d exp=14", match_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) begin
      stim_valid = 1'b1; a = 1'b1; b = 1'(i);
      @(posedge clk); #1;
    end
    stim_valid = 1'b0;
    repeat (13) begin @(posedge clk); #1; end
    n_chk++; if (tmo !== 1'b0) begin n_err++; $display("FAIL timeout_early got=%b exp=0", tmo); end
    @(posedge clk); #1;
    n_chk++; if (tmo !== 1'b1) begin n_err++; $display("FAIL timeout_at16 got=%b exp=1", tmo); end
    n_chk++; if ({busy, fail, pass} !== 3'b010) begin n_err++; $display("FAIL timeout_state got=%b exp=010", {busy, fail, pass}); end
  endtask

  task automatic test_overflow();
    do_reset();
    start_run();
    for (int i = 0; i < 9; i++) begin
      stim_valid = 1'b1; a = 1'b0; b = 1'b1;
      @(posedge clk); #1;
      if (i == 7) begin
        n_chk++; if (ovf !== 1'b0) begin n_err++; $display("FAIL overflow_at_full got=%b exp=0", ovf); end
      end
    end
    stim_valid = 1'b0;
    n_chk++; if ({ovf, fail, busy} !== 3'b111) begin n_err++; $display("FAIL overflow_flags got=%b exp=111", {ovf, fail, busy}); end
  endtask

  task automatic test_underflow();
    do_reset();
    start_run();
    resp_valid = 1'b1; c = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    n_chk++; if (udf !== 1'b1) begin n_err++; $display("FAIL underflow_flag got=%b exp=1", udf); end
    n_chk++; if (mismatch_cnt !== 8'd1) begin n_err++; $display("FAIL underflow_mismatch got=%0d exp=1", mismatch_cnt); end
    n_chk++; if ({fail, busy, match_cnt} !== {2'b11, 8'd0}) begin n_err++; $display("FAIL underflow_state got=%b exp=1100000000", {fail, busy, match_cnt}); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    start_run();
    fill_sweep(8, 1'b0);
    run_sched(N, N);
    n_chk++; if ({busy, match_cnt} !== {1'b1, 8'd6}) begin n_err++; $display("FAIL drain_before_reset got=%b/%0d exp=1/6", busy, match_cnt); end
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, pass, fail, tmo, ovf, udf, match_cnt, mismatch_cnt, fail_vec} !== 26'd0) begin
      n_err++; $display("FAIL drain_async_reset got=%b exp=all zero", {busy, pass, fail, tmo, ovf, udf, match_cnt, mismatch_cnt, fail_vec});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    start_run();
    fill_sweep(1, 1'b0);
    run_sched(N, N + 2);
    wait_done("after_reset");
    n_chk++; if ({pass, match_cnt} !== {1'b1, 8'd14}) begin n_err++; $display("FAIL after_reset_run got=%b/%0d exp=1/14", pass, match_cnt); end
  endtask

  task automatic test_random();
    int t, exp_m, exp_mm, last;
    logic e, g, seen;
    logic [3:0] exp_vec;
    for (int run = 0; run < 6; run++) begin
      do_reset();
      start_run();
      t = 0; last = -1; exp_m = 0; exp_mm = 0; exp_vec = 4'b0000; seen = 1'b0;
      for (int i = 0; i < N; i++) begin
        va[i] = rand4(); vb[i] = rand4();
        g = ~(va[i] & vb[i]);
        if ($urandom_range(0, 3) == 0) g = (g === 1'b0) ? 1'b1 : (g === 1'b1) ? 1'b0 : 1'bz;
        vc[i] = g;
        push_t[i] = t;
        t += 1 + $urandom_range(0, 2);
        resp_t[i] = push_t[i] + 1 + $urandom_range(0, 3);
        if (resp_t[i] <= last) resp_t[i] = last + 1;
        last = resp_t[i];
        e = exp_of(va[i], vb[i]);
        if (judged_ok(e, vc[i])) exp_m++;
        else begin
          exp_mm++;
          if (!seen) begin exp_vec = {va[i], vb[i], e, vc[i]}; seen = 1'b1; end
        end
      end
      run_sched(N, last + 2);
      wait_done("random");
      n_chk++; if (match_cnt !== 8'(exp_m)) begin n_err++; $display("FAIL random%0d_match got=%0d exp=%0d", run, match_cnt, exp_m); end
      n_chk++; if (mismatch_cnt !== 8'(exp_mm)) begin n_err++; $display("FAIL random%0d_mismatch got=%0d exp=%0d", run, mismatch_cnt, exp_mm); end
      n_chk++; if (fail_vec !== exp_vec) begin n_err++; $display("FAIL random%0d_fail_vec got=%b exp=%b", run, fail_vec, exp_vec); end
      n_chk++; if ({pass, fail} !== {(exp_mm == 0), (exp_mm != 0)}) begin
        n_err++; $display("FAIL random%0d_verdict got=%b exp=%b", run, {pass, fail}, {(exp_mm == 0), (exp_mm != 0)});
      end
      n_chk++; if ({tmo, ovf, udf} !== 3'b000) begin n_err++; $display("FAIL random%0d_errors got=%b exp=000", run, {tmo, ovf, udf}); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_sweep();
    test_fault();
    test_full_latency();
    test_timeout();
    test_overflow();
    test_underflow();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
